// File: rtl/regbank_port_ctrl_if.sv
// regbank_port_ctrl_if: bundles the writeback, scoreboard-issue, operand-read and
// register-bank signals of regbank_port_ctrl.
//  slave  : view of the controller
//  master : view of the surrounding pipeline / bank environment
interface regbank_port_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 32
);
    // ALU writeback
    logic                  wa_valid;
    logic                  wa_ready;
    logic [ADDR_WIDTH-1:0] wa_addr;
    logic [WIDTH-1:0]      wa_data;
    // MEM (load) writeback
    logic                  wm_valid;
    logic                  wm_ready;
    logic [ADDR_WIDTH-1:0] wm_addr;
    logic [WIDTH-1:0]      wm_data;
    // Issue marks a destination busy
    logic                  sb_set;
    logic [ADDR_WIDTH-1:0] sb_addr;
    // Operand read
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic [ADDR_WIDTH-1:0] rd_addr2;
    logic                  rd_rsp_valid;
    logic [WIDTH-1:0]      rd_rsp_data1;
    logic [WIDTH-1:0]      rd_rsp_data2;
    // Register bank side
    logic                  read_port_1;
    logic                  read_port_2;
    logic [ADDR_WIDTH-1:0] addr_port_1;
    logic [ADDR_WIDTH-1:0] addr_port_2;
    logic                  write_port;
    logic [ADDR_WIDTH-1:0] addr_port_write;
    logic [WIDTH-1:0]      din_port_write;
    logic [WIDTH-1:0]      dout_port_1;
    logic [WIDTH-1:0]      dout_port_2;

    modport slave (
        input  wa_valid, wa_addr, wa_data,
        input  wm_valid, wm_addr, wm_data,
        input  sb_set, sb_addr,
        input  rd_req_valid, rd_addr1, rd_addr2,
        input  dout_port_1, dout_port_2,
        output wa_ready, wm_ready, rd_req_ready,
        output rd_rsp_valid, rd_rsp_data1, rd_rsp_data2,
        output read_port_1, read_port_2, addr_port_1, addr_port_2,
        output write_port, addr_port_write, din_port_write
    );

    modport master (
        output wa_valid, wa_addr, wa_data,
        output wm_valid, wm_addr, wm_data,
        output sb_set, sb_addr,
        output rd_req_valid, rd_addr1, rd_addr2,
        output dout_port_1, dout_port_2,
        input  wa_ready, wm_ready, rd_req_ready,
        input  rd_rsp_valid, rd_rsp_data1, rd_rsp_data2,
        input  read_port_1, read_port_2, addr_port_1, addr_port_2,
        input  write_port, addr_port_write, din_port_write
    );
endinterface

// File: rtl/regbank_port_ctrl.sv
// regbank_port_ctrl: sequences a register bank with a registered decoder.
//  - Round-robin sharing of the single write port between ALU and MEM writeback.
//  - Scoreboard of busy destinations; operand reads of busy registers stall.
//  - Write pipe: stage 1 drives write enable/address, stage 2 drives data.
//  - Read pipe: enables/addresses one cycle after accept, response 3 cycles after.
// Optional build macro REGBANK_CTRL_PERF_EN adds perf_stall_cnt / perf_conflict_cnt.
module regbank_port_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    regbank_port_ctrl_if.slave bus
`ifdef REGBANK_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_conflict_cnt
`endif
);
    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam logic [NREGS-1:0] ONE_HOT_0 = {{(NREGS-1){1'b0}}, 1'b1};

    // Arbitration
    logic                  prio_mem_r;
    logic                  grant_alu_s;
    logic                  grant_mem_s;
    logic                  wr_accept_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [WIDTH-1:0]      wr_data_s;

    // Scoreboard
    logic [NREGS-1:0]      busy_r;
    logic [NREGS-1:0]      busy_next_s;
    logic [NREGS-1:0]      clr_mask_s;
    logic [NREGS-1:0]      set_mask_s;

    // Read side
    logic                  rd_ready_s;
    logic                  rd_accept_s;
    logic                  rd_s1_valid_r;
    logic                  rd_s2_valid_r;
    logic                  rd_s3_valid_r;
    logic [ADDR_WIDTH-1:0] rd_addr1_r;
    logic [ADDR_WIDTH-1:0] rd_addr2_r;

    // Write side
    logic                  wr_s1_valid_r;
    logic [ADDR_WIDTH-1:0] wr_s1_addr_r;
    logic [WIDTH-1:0]      wr_s1_data_r;
    logic [WIDTH-1:0]      din_r;

    // Write arbiter: a lone requester wins; on conflict the source not granted last wins.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        if (bus.wa_valid && bus.wm_valid) begin
            if (prio_mem_r) begin
                grant_mem_s = 1'b1;
            end else begin
                grant_alu_s = 1'b1;
            end
        end else if (bus.wa_valid) begin
            grant_alu_s = 1'b1;
        end else if (bus.wm_valid) begin
            grant_mem_s = 1'b1;
        end else begin
            grant_alu_s = 1'b0;
            grant_mem_s = 1'b0;
        end
    end

    // Select the address/data of the granted writeback source.
    always_comb begin
        wr_addr_s = bus.wa_addr;
        wr_data_s = bus.wa_data;
        if (grant_mem_s) begin
            wr_addr_s = bus.wm_addr;
            wr_data_s = bus.wm_data;
        end else begin
            wr_addr_s = bus.wa_addr;
            wr_data_s = bus.wa_data;
        end
    end

    assign wr_accept_s  = grant_alu_s | grant_mem_s;
    assign bus.wa_ready = grant_alu_s;
    assign bus.wm_ready = grant_mem_s;

    // Set is applied after clear so an issue on the same edge as the write keeps the bit busy.
    assign clr_mask_s  = wr_accept_s ? (ONE_HOT_0 << wr_addr_s) : {NREGS{1'b0}};
    assign set_mask_s  = bus.sb_set  ? (ONE_HOT_0 << bus.sb_addr) : {NREGS{1'b0}};
    assign busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;

    // Reads proceed only when neither source register has a write outstanding.
    assign rd_ready_s       = ~busy_r[bus.rd_addr1] & ~busy_r[bus.rd_addr2];
    assign rd_accept_s      = bus.rd_req_valid & rd_ready_s;
    assign bus.rd_req_ready = rd_ready_s;

    // Round-robin pointer: after each grant, favour the other source on the next conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_mem_r <= 1'b0;
        end else if (wr_accept_s) begin
            prio_mem_r <= grant_alu_s;
        end
    end

    // Busy-bit scoreboard update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Write pipe: stage 1 presents enable/address, stage 2 presents data (held when idle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_s1_valid_r <= 1'b0;
            wr_s1_addr_r  <= {ADDR_WIDTH{1'b0}};
            wr_s1_data_r  <= {WIDTH{1'b0}};
            din_r         <= {WIDTH{1'b0}};
        end else begin
            wr_s1_valid_r <= wr_accept_s;
            if (wr_accept_s) begin
                wr_s1_addr_r <= wr_addr_s;
                wr_s1_data_r <= wr_data_s;
            end
            if (wr_s1_valid_r) begin
                din_r <= wr_s1_data_r;
            end
        end
    end

    // Read pipe: enables one cycle after accept, response valid when bank data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1_valid_r <= 1'b0;
            rd_s2_valid_r <= 1'b0;
            rd_s3_valid_r <= 1'b0;
            rd_addr1_r    <= {ADDR_WIDTH{1'b0}};
            rd_addr2_r    <= {ADDR_WIDTH{1'b0}};
        end else begin
            rd_s1_valid_r <= rd_accept_s;
            rd_s2_valid_r <= rd_s1_valid_r;
            rd_s3_valid_r <= rd_s2_valid_r;
            if (rd_accept_s) begin
                rd_addr1_r <= bus.rd_addr1;
                rd_addr2_r <= bus.rd_addr2;
            end
        end
    end

    assign bus.write_port      = wr_s1_valid_r;
    assign bus.addr_port_write = wr_s1_addr_r;
    assign bus.din_port_write  = din_r;
    assign bus.read_port_1     = rd_s1_valid_r;
    assign bus.read_port_2     = rd_s1_valid_r;
    assign bus.addr_port_1     = rd_addr1_r;
    assign bus.addr_port_2     = rd_addr2_r;
    assign bus.rd_rsp_valid    = rd_s3_valid_r;
    assign bus.rd_rsp_data1    = bus.dout_port_1;
    assign bus.rd_rsp_data2    = bus.dout_port_2;

`ifdef REGBANK_CTRL_PERF_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_conflict_r;

    // Performance counters: stalled read cycles and write-port conflict cycles (wrapping).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_r    <= 32'd0;
            perf_conflict_r <= 32'd0;
        end else begin
            if (bus.rd_req_valid && !rd_ready_s) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
            if (bus.wa_valid && bus.wm_valid) begin
                perf_conflict_r <= perf_conflict_r + 32'd1;
            end
        end
    end

    assign perf_stall_cnt    = perf_stall_r;
    assign perf_conflict_cnt = perf_conflict_r;
`endif
endmodule
